// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered opcode-selected bitwise unit with valid/ready handshake,
// 2-entry output FIFO and a saturating count of popped results.
module logic_unit_pipe #(
  parameter int N_BITS   = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [N_BITS-1:0]   A,
  input  logic [N_BITS-1:0]   B,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_BITS-1:0]   Y,
  output logic                zero,
  output logic [CNT_BITS-1:0] op_count
);
  logic [1:0]        count;
  logic [N_BITS:0]   head, tail;
  logic [N_BITS-1:0] res;
  logic              push, pop;
  logic [1:0]        wr;
  always_comb begin
    res = ~A;
    case (op)
      3'b001: res = A & B;
      3'b010: res = A | B;
      3'b011: res = A ^ B;
      3'b100: res = ~(A & B);
      3'b101: res = ~(A | B);
      3'b110: res = ~(A ^ B);
      3'b111: res = A;
      default: res = ~A;
    endcase
  end
  assign in_ready  = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // slot the new entry lands in, after any same-cycle pop has shifted the tail forward
  assign wr        = count - {1'b0, pop};
  assign {Y, zero} = head;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      op_count <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) head <= tail;
      if (push && wr == 2'd0) head <= {res, ~|res};
      if (push && wr != 2'd0) tail <= {res, ~|res};
      if (pop && ~&op_count) op_count <= op_count + CNT_BITS'(1);
    end
  end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: randomized and directed checks of logic_unit_pipe against a queue-based model.
module tb_logic_unit_pipe;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0, out_ready = 0;
  logic [2:0] op = 0;
  logic [7:0] a = 0, b = 0;
  logic       in_ready, out_valid, zero;
  logic [7:0] y;
  logic [3:0] op_count;
  logic       v1 = 0, a1 = 0, b1 = 0, r1, ov1, y1, z1;
  logic       v32 = 0, r32, ov32, z32;
  logic [31:0] a32 = 0, b32 = 0, y32;
  logic [2:0] op1 = 0, op32 = 0;
  logic [3:0] oc1;
  logic [3:0] oc32;
  int tests = 0, fails = 0;
  logic [8:0] q[$];
  int pops = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.N_BITS(8), .CNT_BITS(4)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready), .Y(y), .zero(zero), .op_count(op_count));
  logic_unit_pipe #(.N_BITS(1), .CNT_BITS(4)) dut1 (
    .clk(clk), .reset(rst_n), .in_valid(v1), .in_ready(r1), .op(op1), .A(a1), .B(b1),
    .out_valid(ov1), .out_ready(1'b1), .Y(y1), .zero(z1), .op_count(oc1));
  logic_unit_pipe #(.N_BITS(32), .CNT_BITS(4)) dut32 (
    .clk(clk), .reset(rst_n), .in_valid(v32), .in_ready(r32), .op(op32), .A(a32), .B(b32),
    .out_valid(ov32), .out_ready(1'b1), .Y(y32), .zero(z32), .op_count(oc32));

  function automatic logic [7:0] ref_fn(input logic [2:0] f, input logic [7:0] x, input logic [7:0] z);
    logic [7:0] r;
    case (f)
      3'd0: r = ~x;
      3'd1: r = x & z;
      3'd2: r = x | z;
      3'd3: r = x ^ z;
      3'd4: r = ~(x & z);
      3'd5: r = ~(x | z);
      3'd6: r = ~(x ^ z);
      default: r = x;
    endcase
    return r;
  endfunction

  // advance one clock, updating the model from the inputs presented at this edge
  task automatic cycle();
    logic acc, pp;
    logic [7:0] r;
    @(posedge clk);
    acc = in_valid && q.size() < 2;
    pp  = out_ready && q.size() > 0;
    r   = ref_fn(op, a, b);
    if (pp) begin void'(q.pop_front()); pops++; end
    if (acc) q.push_back({r, r == 8'd0});
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (out_valid !== 1'b0 || y !== 8'h00 || zero !== 1'b0 || op_count !== 4'h0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_init: ov=%b y=%h z=%b cnt=%h rdy=%b required 0 00 0 0 1", out_valid, y, zero, op_count, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_y[8];
    exp_y = '{8'h3A, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hC5};
    a = 8'hC5; b = 8'h3A; out_ready = 1; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      cycle();
      tests++;
      if (out_valid !== 1'b1 || y !== exp_y[i] || zero !== (exp_y[i] == 8'h00) || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL all_ops op=%0d: ov=%b y=%h z=%b rdy=%b required 1 %h %b 1", i, out_valid, y, zero, in_ready, exp_y[i], exp_y[i] == 8'h00);
      end
    end
    in_valid = 0;
    cycle();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL all_ops_drain: ov=%b required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] first;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      cycle();
      tests++;
      if (in_ready !== (i == 0) || q.size() != ((i == 0) ? 1 : 2)) begin
        fails++;
        $display("FAIL bp_ready i=%0d: rdy=%b required %b", i, in_ready, i == 0);
      end
    end
    first = q[0][8:1];
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (y !== first || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_stall: y=%h ov=%b rdy=%b required %h 1 0", y, out_valid, in_ready, first);
      end
    end
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) in_valid = 0;
      tests++;
      if (out_valid !== (q.size() != 0) || (q.size() != 0 && {y, zero} !== q[0])) begin
        fails++;
        $display("FAIL bp_drain i=%0d: ov=%b y=%h z=%b required %b %h", i, out_valid, y, zero, q.size() != 0, q.size() ? q[0] : 9'h0);
      end
      cycle();
    end
  endtask

  task automatic test_simultaneous();
    int p0;
    out_ready = 0; in_valid = 1; op = 3'd3; a = 8'h5A; b = 8'h0F;
    cycle();
    out_ready = 1;
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      cycle();
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || q.size() != 1 || {y, zero} !== q[0]) begin
        fails++;
        $display("FAIL simul i=%0d: rdy=%b ov=%b y=%h z=%b required 1 1 %h", i, in_ready, out_valid, y, zero, q[0]);
      end
    end
    tests++;
    if (pops - p0 != 10) begin fails++; $display("FAIL simul_pops: got %0d required 10", pops - p0); end
    in_valid = 0;
    cycle();
  endtask

  task automatic test_saturation();
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 22; i++) begin
      op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      cycle();
      tests++;
      if (op_count !== 4'((pops > 15) ? 15 : pops)) begin
        fails++;
        $display("FAIL sat i=%0d: cnt=%h required %h", i, op_count, (pops > 15) ? 15 : pops);
      end
    end
    in_valid = 0;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      cycle();
      tests++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2) ||
          (q.size() != 0 && {y, zero} !== q[0]) || op_count !== 4'((pops > 15) ? 15 : pops)) begin
        fails++;
        $display("FAIL rand i=%0d: ov=%b rdy=%b y=%h z=%b cnt=%h required ov=%b rdy=%b head=%h cnt=%0d",
                 i, out_valid, in_ready, y, zero, op_count, q.size() != 0, q.size() < 2, q.size() ? q[0] : 9'h0, (pops > 15) ? 15 : pops);
      end
    end
    in_valid = 0; out_ready = 0;
  endtask

  task automatic test_reset_midstream();
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      op = 3'($urandom_range(0, 7)); a = 8'($urandom | 1); b = 8'($urandom);
      cycle();
    end
    in_valid = 0;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL mid_prefill: ov=%b rdy=%b required 1 0", out_valid, in_ready); end
    rst_n = 0;
    #1;
    q.delete(); pops = 0;
    tests++;
    if (out_valid !== 1'b0 || y !== 8'h00 || zero !== 1'b0 || op_count !== 4'h0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: ov=%b y=%h z=%b cnt=%h rdy=%b required 0 00 0 0 1", out_valid, y, zero, op_count, in_ready);
    end
    #2 rst_n = 1;
    out_ready = 1;
    cycle();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_mid_after: ov=%b required 0", out_valid); end
  endtask

  task automatic test_width();
    op1 = 3'd0; a1 = 1'b1; b1 = 1'b0; v1 = 1;
    op32 = 3'd3; a32 = 32'hDEADBEEF; b32 = 32'hDEADBEEF; v32 = 1;
    @(posedge clk); @(negedge clk);
    v1 = 0; v32 = 0;
    tests++;
    if (ov1 !== 1'b1 || y1 !== 1'b0 || z1 !== 1'b1) begin
      fails++; $display("FAIL width1: ov=%b y=%b z=%b required 1 0 1", ov1, y1, z1);
    end
    tests++;
    if (ov32 !== 1'b1 || y32 !== 32'h0 || z32 !== 1'b1) begin
      fails++; $display("FAIL width32: ov=%b y=%h z=%b required 1 00000000 1", ov32, y32, z32);
    end
  endtask

  initial begin
    test_reset();
    test_all_ops();
    test_backpressure();
    test_simultaneous();
    test_saturation();
    test_random();
    test_reset_midstream();
    test_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
